// File: rtl/packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : packer_pkg
// Brief    : Shared types and helpers for the nibble packer and its FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package packer_pkg;

    localparam int NIB_W    = 4;
    localparam int MAX_NIBS = 8;
    localparam int MAX_W    = NIB_W * MAX_NIBS;

    typedef logic [NIB_W-1:0] nib_t;

    // Sized for the widest legal word; narrower configurations leave the top bits zero.
    typedef struct packed {
        logic [MAX_W-1:0] word;
        logic [3:0]       len;
    } entry_t;

    function automatic int idx_w(input int nibs);
        return (nibs < 2) ? 1 : $clog2(nibs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/packer_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : packer_fifo2
// Brief    : Two-entry word FIFO, push and pop allowed together at any fill.
// Revision : 1.0 - initial release
// ============================================================================
module packer_fifo2
    import packer_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       i_push,
    input  entry_t     i_data,
    input  logic       i_pop,
    output entry_t     o_head,
    output logic [1:0] o_count
);

    entry_t     r_mem [2];
    logic       r_rd_ptr;
    logic       r_wr_ptr;
    logic [1:0] r_count;
    logic       w_do_pop;
    logic       w_do_push;

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/nibble_packer.sv
`default_nettype none
// ============================================================================
// Module   : nibble_packer
// Brief    : Packs upstream nibbles LSB-first into words, with flush of partials.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_packer
    import packer_pkg::*;
#(
    parameter  int NIBS = 4,
    localparam int W    = NIB_W * NIBS
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  nib_t         nib_data,
    input  logic         nib_valid,
    output logic         nib_take,
    input  logic         EN_flush,
    output logic         RDY_flush,
    input  logic         EN_word,
    output logic [W-1:0] word,
    output logic [3:0]   word_len,
    output logic         RDY_word,
    output logic [7:0]   overflow_cnt
);

    localparam int                 c_cnt_w    = idx_w(NIBS);
    localparam logic [c_cnt_w-1:0] c_last     = c_cnt_w'(NIBS - 1);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);
    localparam logic [3:0]         c_full_len = 4'(NIBS);

    logic [W-1:0]       r_acc;
    logic [c_cnt_w-1:0] r_cnt;
    logic [7:0]         r_ovf;

    logic [1:0]         w_fifo_cnt;
    entry_t             w_head;
    entry_t             w_push_entry;
    logic               w_push;
    logic [W-1:0]       w_merged;
    logic [W-1:0]       w_push_word;
    logic [3:0]         w_push_len;
    logic               w_can_push;
    logic               w_flush_ok;
    logic               w_last;

    assign w_last     = (r_cnt == c_last);
    assign w_can_push = (w_fifo_cnt != 2'd2) || EN_word;
    assign nib_take   = nib_valid && (!w_last || w_can_push);
    assign RDY_flush  = (w_fifo_cnt != 2'd2);
    assign w_flush_ok = EN_flush && RDY_flush;

    // The incoming nibble is merged before any flush so one push covers both.
    always_comb begin
        w_merged    = r_acc;
        w_push      = 1'b0;
        w_push_word = '0;
        w_push_len  = 4'd0;
        if (nib_take) w_merged[NIB_W*r_cnt +: NIB_W] = nib_data;
        if (nib_take && w_last) begin
            w_push      = 1'b1;
            w_push_word = w_merged;
            w_push_len  = c_full_len;
        end else if (w_flush_ok && nib_take) begin
            w_push      = 1'b1;
            w_push_word = w_merged;
            w_push_len  = 4'(r_cnt) + 4'd1;
        end else if (w_flush_ok && (r_cnt != '0)) begin
            w_push      = 1'b1;
            w_push_word = r_acc;
            w_push_len  = 4'(r_cnt);
        end
    end

    assign w_push_entry.word = MAX_W'(w_push_word);
    assign w_push_entry.len  = w_push_len;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 8'd0;
        end else begin
            if (w_push) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (nib_take) begin
                r_acc <= w_merged;
                r_cnt <= r_cnt + c_one;
            end
            if (EN_flush && !RDY_flush && (r_ovf != 8'hFF)) r_ovf <= r_ovf + 8'd1;
        end
    end

    packer_fifo2 u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (EN_word),
        .o_head  (w_head),
        .o_count (w_fifo_cnt)
    );

    generate
        if (W < MAX_W) begin : g_hi_bits
            logic w_unused_hi;
            assign w_unused_hi = |w_head.word[MAX_W-1:W];
        end
    endgenerate

    assign word         = w_head.word[W-1:0];
    assign word_len     = w_head.len;
    assign RDY_word     = (w_fifo_cnt != 2'd0);
    assign overflow_cnt = r_ovf;

endmodule
`default_nettype wire
